// File: rtl/async_sram_phy_timed.sv
// Timed async SRAM PHY: turns one request handshake into a full external
// read or write cycle with programmable setup/access/pulse/turn timing.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_t_*              setup, access-1, wpulse-1, turnaround (clk cycles)
//   req_*                request handshake (valid/ready, write, addr, wdata, bmask)
//   rsp_valid/rsp_rdata  one-cycle read response, data held until next read
//   busy                 transfer or turnaround in progress
//   padin/padout/padoe   SRAM pad ring signals, all outputs registered
module async_sram_phy_timed #(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16,
    parameter int W_TIMING  = 4,
    localparam int NB       = N_SRAM_DQ / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_TIMING-1:0]  cfg_t_setup,
    input  logic [W_TIMING-1:0]  cfg_t_access,
    input  logic [W_TIMING-1:0]  cfg_t_wpulse,
    input  logic [W_TIMING-1:0]  cfg_t_turn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [N_SRAM_A-1:0]  req_addr,
    input  logic [N_SRAM_DQ-1:0] req_wdata,
    input  logic [NB-1:0]        req_bmask,
    output logic                 rsp_valid,
    output logic [N_SRAM_DQ-1:0] rsp_rdata,
    output logic                 busy,
    input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
    output logic [N_SRAM_DQ-1:0] padout_sram_dq,
    output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
    output logic [N_SRAM_A-1:0]  padout_sram_a,
    output logic                 padout_sram_cs_n,
    output logic                 padout_sram_oe_n,
    output logic                 padout_sram_we_n,
    output logic [NB-1:0]        padout_sram_byte_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_ACCESS,
        WR_PULSE,
        WR_HOLD,
        TURN
    } state_t;

    localparam logic [W_TIMING:0] CNT_ONE = {{W_TIMING{1'b0}}, 1'b1};

    state_t              state;
    logic [W_TIMING:0]   cnt;
    logic                wr;
    logic [W_TIMING-1:0] t_access;
    logic [W_TIMING-1:0] t_wpulse;
    logic [W_TIMING-1:0] t_turn;

    // One extra counter bit so a maximum cfg value never wraps.
    function automatic logic [W_TIMING:0] ext(input logic [W_TIMING-1:0] v);
        return {1'b0, v};
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            wr                 <= 1'b0;
            t_access           <= '0;
            t_wpulse           <= '0;
            t_turn             <= '0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            padout_sram_dq     <= '0;
            padoe_sram_dq      <= '0;
            padout_sram_a      <= '0;
            padout_sram_cs_n   <= 1'b1;
            padout_sram_oe_n   <= 1'b1;
            padout_sram_we_n   <= 1'b1;
            padout_sram_byte_n <= '1;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr               <= req_write;
                        t_access         <= cfg_t_access;
                        t_wpulse         <= cfg_t_wpulse;
                        t_turn           <= cfg_t_turn;
                        padout_sram_a    <= req_addr;
                        padout_sram_cs_n <= 1'b0;
                        if (req_write) begin
                            // Writes always get at least one setup cycle
                            // so DQ is driven before we_n falls.
                            padout_sram_byte_n <= ~req_bmask;
                            padoe_sram_dq      <= '1;
                            padout_sram_dq     <= req_wdata;
                            state              <= SETUP;
                            cnt <= (cfg_t_setup == '0) ? '0
                                 : ext(cfg_t_setup) - CNT_ONE;
                        end else begin
                            padout_sram_byte_n <= '0;
                            if (cfg_t_setup == '0) begin
                                state            <= RD_ACCESS;
                                padout_sram_oe_n <= 1'b0;
                                cnt              <= ext(cfg_t_access);
                            end else begin
                                state <= SETUP;
                                cnt   <= ext(cfg_t_setup) - CNT_ONE;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        if (wr) begin
                            state            <= WR_PULSE;
                            padout_sram_we_n <= 1'b0;
                            cnt              <= ext(t_wpulse);
                        end else begin
                            state            <= RD_ACCESS;
                            padout_sram_oe_n <= 1'b0;
                            cnt              <= ext(t_access);
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RD_ACCESS: begin
                    if (cnt == '0) begin
                        padout_sram_oe_n   <= 1'b1;
                        rsp_valid          <= 1'b1;
                        rsp_rdata          <= padin_sram_dq;
                        padout_sram_cs_n   <= 1'b1;
                        padout_sram_byte_n <= '1;
                        padoe_sram_dq      <= '0;
                        if (t_turn == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= TURN;
                            cnt   <= ext(t_turn) - CNT_ONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        padout_sram_we_n <= 1'b1;
                        state            <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_HOLD: begin
                    padout_sram_cs_n   <= 1'b1;
                    padout_sram_byte_n <= '1;
                    padoe_sram_dq      <= '0;
                    if (t_turn == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= TURN;
                        cnt   <= ext(t_turn) - CNT_ONE;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_sram_phy_timed.sv
// Testbench for async_sram_phy_timed: cycle-accurate strobe timing checks
// plus a scoreboard of expected read data.
module tb_async_sram_phy_timed;

    logic        clk;
    logic        rst;
    logic [3:0]  cfg_t_setup;
    logic [3:0]  cfg_t_access;
    logic [3:0]  cfg_t_wpulse;
    logic [3:0]  cfg_t_turn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_bmask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [15:0] padin_sram_dq;
    logic [15:0] padout_sram_dq;
    logic [15:0] padoe_sram_dq;
    logic [17:0] padout_sram_a;
    logic        padout_sram_cs_n;
    logic        padout_sram_oe_n;
    logic        padout_sram_we_n;
    logic [1:0]  padout_sram_byte_n;

    async_sram_phy_timed dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_t_setup        (cfg_t_setup),
        .cfg_t_access       (cfg_t_access),
        .cfg_t_wpulse       (cfg_t_wpulse),
        .cfg_t_turn         (cfg_t_turn),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_bmask          (req_bmask),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .busy               (busy),
        .padin_sram_dq      (padin_sram_dq),
        .padout_sram_dq     (padout_sram_dq),
        .padoe_sram_dq      (padoe_sram_dq),
        .padout_sram_a      (padout_sram_a),
        .padout_sram_cs_n   (padout_sram_cs_n),
        .padout_sram_oe_n   (padout_sram_oe_n),
        .padout_sram_we_n   (padout_sram_we_n),
        .padout_sram_byte_n (padout_sram_byte_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rsp_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    // per-cycle records, bit k = value in cycle k after acceptance
    logic [31:0] cs_v, oe_v, we_v, rv_v, rdy_v, drv_v;
    int          oe_low, we_low;
    logic [17:0] a1, a4;
    logic [1:0]  bn1;
    logic [15:0] dq1;
    int          rc0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_rec();
        cs_v = '0; oe_v = '0; we_v = '0; rv_v = '0; rdy_v = '0; drv_v = '0;
        oe_low = 0; we_low = 0;
    endtask

    task automatic sample(input int k);
        cs_v[k]  = padout_sram_cs_n;
        oe_v[k]  = padout_sram_oe_n;
        we_v[k]  = padout_sram_we_n;
        rv_v[k]  = rsp_valid;
        rdy_v[k] = req_ready;
        drv_v[k] = &padoe_sram_dq;
        if (!padout_sram_oe_n) oe_low++;
        if (!padout_sram_we_n) we_low++;
        if (k == 1) begin
            a1  = padout_sram_a;
            bn1 = padout_sram_byte_n;
            dq1 = padout_sram_dq;
        end
        if (k == 4) a4 = padout_sram_a;
    endtask

    // One request, then n cycles recorded; chg_k > 0 changes cfg_t_access
    // mid-transfer to show the config is latched.
    task automatic run_req(input logic wr, input logic [17:0] a,
                           input logic [15:0] d, input logic [1:0] m,
                           input int n, input int chg_k);
        clr_rec();
        check("rdy_pre", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_bmask = m;
        cyc();
        req_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            sample(k);
            if (k == chg_k) cfg_t_access = 4'd7;
            cyc();
        end
    endtask

    // scoreboard consumer and strobe invariants
    always @(posedge clk) begin
        #1;
        check("inv_strobe", padout_sram_oe_n | padout_sram_we_n, 1);
        check("inv_padoe", !padout_sram_oe_n && (|padoe_sram_dq), 0);
        if (rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_unexp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_rdata, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cfg_t_setup = 4'd0; cfg_t_access = 4'd0;
        cfg_t_wpulse = 4'd0; cfg_t_turn = 4'd0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_bmask = '0; padin_sram_dq = '0;
        repeat (3) cyc();
        check("rst_cs", padout_sram_cs_n, 1);
        check("rst_oe", padout_sram_oe_n, 1);
        check("rst_we", padout_sram_we_n, 1);
        check("rst_byte", padout_sram_byte_n, 2'b11);
        check("rst_padoe", padoe_sram_dq, 16'h0);
        check("rst_a", padout_sram_a, 18'h0);
        check("rst_rv", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 16'h0);
        rst = 1'b0;
        cyc();
        check("rst_rdy", req_ready, 1);
        check("rst_busy", busy, 0);

        // basic read
        cfg_t_setup = 4'd1; cfg_t_access = 4'd2; cfg_t_turn = 4'd1;
        padin_sram_dq = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        run_req(1'b0, 18'h12345, 16'h0, 2'b00, 6, 0);
        check("rd_cs", cs_v, 32'h60);
        check("rd_oe", oe_v, 32'h62);
        check("rd_rv", rv_v, 32'h20);
        check("rd_rdy", rdy_v, 32'h40);
        check("rd_a", a1, 18'h12345);
        check("rd_byte", bn1, 2'b00);

        // basic write, setup 0 forced to 1
        cfg_t_setup = 4'd0; cfg_t_wpulse = 4'd1; cfg_t_turn = 4'd0;
        rc0 = rsp_cnt;
        run_req(1'b1, 18'h00ABC, 16'hA55A, 2'b10, 5, 0);
        check("wr_cs", cs_v, 32'h20);
        check("wr_we", we_v, 32'h32);
        check("wr_oe", oe_v, 32'h3E);
        check("wr_drv", drv_v, 32'h1E);
        check("wr_byte", bn1, 2'b01);
        check("wr_dq", dq1, 16'hA55A);
        check("wr_rdy", rdy_v, 32'h20);
        cyc();
        check("wr_norsp", rsp_cnt, rc0);

        // config latched at acceptance
        cfg_t_setup = 4'd1; cfg_t_access = 4'd2; cfg_t_turn = 4'd1;
        padin_sram_dq = 16'h1234;
        exp_q.push_back(16'h1234);
        run_req(1'b0, 18'h00055, 16'h0, 2'b00, 6, 2);
        check("cfg_oe", oe_v, 32'h62);
        check("cfg_oelen", oe_low, 3);
        cfg_t_access = 4'd2;

        // maximum access value: 16 strobe cycles, no wrap
        cfg_t_setup = 4'd0; cfg_t_access = 4'd15; cfg_t_turn = 4'd0;
        padin_sram_dq = 16'h7E81;
        exp_q.push_back(16'h7E81);
        run_req(1'b0, 18'h3FFFF, 16'h0, 2'b00, 20, 0);
        check("max_oelen", oe_low, 16);
        check("max_rv", rv_v, 32'h20000);
        check("max_a", a1, 18'h3FFFF);

        // empty byte mask write still runs full timing
        cfg_t_setup = 4'd2; cfg_t_wpulse = 4'd0; cfg_t_turn = 4'd2;
        rc0 = rsp_cnt;
        run_req(1'b1, 18'h00100, 16'h1111, 2'b00, 7, 0);
        check("em_byte", bn1, 2'b11);
        check("em_welen", we_low, 1);
        check("em_we", we_v, 32'hF6);
        check("em_cs", cs_v, 32'hE0);
        check("em_rdy", rdy_v, 32'h80);
        check("em_norsp", rsp_cnt, rc0);

        // reset during write pulse
        cfg_t_setup = 4'd1; cfg_t_wpulse = 4'd3; cfg_t_turn = 4'd1;
        rc0 = rsp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 18'h00777;
        req_wdata = 16'h5A5A; req_bmask = 2'b11;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        check("rw_we_pre", padout_sram_we_n, 0);
        rst = 1'b1;
        cyc();
        check("rw_we", padout_sram_we_n, 1);
        check("rw_cs", padout_sram_cs_n, 1);
        check("rw_oe", padout_sram_oe_n, 1);
        check("rw_padoe", padoe_sram_dq, 16'h0);
        check("rw_rv", rsp_valid, 0);
        rst = 1'b0;
        cyc();
        check("rw_rdy", req_ready, 1);
        check("rw_norsp", rsp_cnt, rc0);

        // back-to-back reads with req_valid held
        cfg_t_setup = 4'd0; cfg_t_access = 4'd1; cfg_t_turn = 4'd0;
        clr_rec();
        padin_sram_dq = 16'hC001;
        exp_q.push_back(16'hC001);
        req_write = 1'b0; req_addr = 18'h00AAA; req_valid = 1'b1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            sample(k);
            if (k == 3) begin
                padin_sram_dq = 16'hC002;
                req_addr = 18'h00BBB;
                exp_q.push_back(16'hC002);
            end
            if (k == 4) req_valid = 1'b0;
            cyc();
        end
        check("b2b_oe", oe_v, 32'hC8);
        check("b2b_cs", cs_v, 32'hC8);
        check("b2b_rv", rv_v, 32'h48);
        check("b2b_rdy", rdy_v, 32'hC8);
        check("b2b_a2", a4, 18'h00BBB);

        repeat (3) cyc();
        check("sb_empty", exp_q.size(), 0);
        check("rsp_total", rsp_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
